// File: rtl/trace_pkg.sv
// trace_pkg: shared types, widths and helpers for the register-write trace buffer
package trace_pkg;
  localparam int SEQ_W  = 16;
  localparam int OVF_W  = 16;
  localparam int XLEN_D = 32;
  localparam int PC_W_D = 32;
  localparam int NREG_D = 32;
  localparam int AW_D   = $clog2(NREG_D);
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [PC_W_D-1:0] pc;
    logic [AW_D-1:0]   addr;
    logic [XLEN_D-1:0] data;
  } trace_entry_t;
  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous first-word-fall-through FIFO of trace entries
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and entry; accept says it was taken this cycle
//   ready        consumer pops the head when valid && ready
//   valid, dout  head entry (registered storage, no path from din)
//   count, full, empty  registered occupancy
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  output logic                   accept,
  input  logic                   ready,
  output logic                   valid,
  output T                       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_N = (PW+1)'(DEPTH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_nxt;
  logic          pop;
  T              mem [DEPTH];
  assign valid  = !empty;
  assign pop    = valid && ready;
  // a full FIFO still accepts when the head leaves on the same edge
  assign accept = push && (!full || pop);
  assign dout   = mem[rd_ptr];
  always_comb
    count_nxt = (accept && !pop) ? count + 1'b1 :
                (!accept && pop) ? count - 1'b1 : count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= count_nxt == FULL_N;
      empty <= count_nxt == '0;
    end
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= din;
endmodule

// File: rtl/reg_trace_buffer.sv
// reg_trace_buffer: captures register-file writes into a sequenced FWFT trace FIFO
//   clk, rst                  clock, asynchronous active-high reset
//   en                        capture enable
//   wr_valid/addr/data/pc     tapped register-file write port
//   out_valid/ready           drain handshake; out_seq/pc/addr/data = head entry
//   count, full, empty        FIFO occupancy
//   overflow_cnt              saturating count of events dropped on a full FIFO
// Optional: define TRACE_FILTER_UNCHANGED_EN to skip writes that do not change
// the register value (tracked in a shadow register file).
module reg_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int PC_W  = PC_W_D,
  parameter int NREG  = NREG_D,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wr_valid,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic [PC_W-1:0]        wr_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [PC_W-1:0]        out_pc,
  output logic [AW-1:0]          out_addr,
  output logic [XLEN-1:0]        out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [OVF_W-1:0]       overflow_cnt
);
  logic [SEQ_W-1:0] seq;
  logic             qualify, accept, drop, changed;
  trace_entry_t     din, dout;
`ifdef TRACE_FILTER_UNCHANGED_EN
  logic [XLEN-1:0] shadow [NREG];
  assign changed = shadow[wr_addr] != wr_data;
  // the shadow mirrors the register file even when capture is off or full
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    else if (wr_valid && wr_addr != '0) shadow[wr_addr] <= wr_data;
`else
  assign changed = 1'b1;
`endif
  assign qualify = en && wr_valid && wr_addr != '0 && changed;
  assign drop    = qualify && !accept;
  assign din     = '{seq: seq, pc: wr_pc, addr: wr_addr, data: wr_data};
  // dropped events still consume a sequence number so gaps reveal losses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seq          <= '0;
      overflow_cnt <= '0;
    end else begin
      if (qualify) seq <= seq + 1'b1;
      if (drop) overflow_cnt <= sat_inc(overflow_cnt);
    end
  trace_fifo #(.DEPTH(DEPTH), .T(trace_entry_t)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (qualify),
    .din    (din),
    .accept (accept),
    .ready  (out_ready),
    .valid  (out_valid),
    .dout   (dout),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );
  assign out_seq  = dout.seq;
  assign out_pc   = dout.pc;
  assign out_addr = dout.addr;
  assign out_data = dout.data;
endmodule

// File: tb/tb_reg_trace_buffer.sv
// tb_reg_trace_buffer: directed self-checking bench for reg_trace_buffer
module tb_reg_trace_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] wr_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_seq;
  logic [31:0] out_pc;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        full, empty;
  logic [15:0] overflow_cnt;
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] uniq = 32'h1000;

  always #5 clk = ~clk;

  reg_trace_buffer dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_pc(wr_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_seq(out_seq), .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b0; out_ready = 1'b0; en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_pc = pc;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wr_u(input logic [4:0] a);
    uniq = uniq + 1;
    wr(a, uniq, 32'h400);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    vecs++; if (count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d want 0", count); end
    vecs++; if (empty !== 1'b1 || full !== 1'b0) begin errs++; $display("FAIL reset_flags got empty=%0b full=%0b want 1/0", empty, full); end
    vecs++; if (overflow_cnt !== 16'd0) begin errs++; $display("FAIL reset_ovf got %0h want 0", overflow_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    wr(5'd5, 32'h11, 32'h100);
    vecs++; if (out_valid !== 1'b1 || out_seq !== 16'd0 || out_pc !== 32'h100 || out_addr !== 5'd5 || out_data !== 32'h11)
      begin errs++; $display("FAIL basic_entry got v=%0b seq=%0h pc=%0h a=%0d d=%0h want 1/0/100/5/11", out_valid, out_seq, out_pc, out_addr, out_data); end
    wr(5'd0, 32'h22, 32'h104);
    vecs++; if (out_valid !== 1'b0 || count !== 5'd0) begin errs++; $display("FAIL basic_x0 got v=%0b count=%0d want 0/0", out_valid, count); end
    en = 1'b0;
    wr(5'd7, 32'h33, 32'h108);
    vecs++; if (count !== 5'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL basic_en_off got count=%0d v=%0b want 0/0", count, out_valid); end
    en = 1'b1; out_ready = 1'b0;
    wr(5'd7, 32'h44, 32'h10C);
    vecs++; if (out_seq !== 16'd1 || count !== 5'd1 || out_data !== 32'h44) begin errs++; $display("FAIL basic_seq_after_en got seq=%0d count=%0d d=%0h want 1/1/44", out_seq, count, out_data); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) wr_u(5'(i + 1));
    vecs++; if (full !== 1'b1 || count !== 5'd16 || overflow_cnt !== 16'd0) begin errs++; $display("FAIL full_fill got full=%0b count=%0d ovf=%0d want 1/16/0", full, count, overflow_cnt); end
    wr_u(5'd20);
    vecs++; if (full !== 1'b1 || count !== 5'd16 || overflow_cnt !== 16'd1) begin errs++; $display("FAIL full_drop got full=%0b count=%0d ovf=%0d want 1/16/1", full, count, overflow_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vecs++; if (out_valid !== 1'b1 || out_seq !== 16'(i)) begin errs++; $display("FAIL full_drain[%0d] got v=%0b seq=%0d want 1/%0d", i, out_valid, out_seq, i); end
      @(negedge clk);
    end
    vecs++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL full_drained got empty=%0b v=%0b want 1/0", empty, out_valid); end
    out_ready = 1'b0;
    wr_u(5'd9);
    vecs++; if (out_seq !== 16'd17 || count !== 5'd1) begin errs++; $display("FAIL full_next_seq got seq=%0d count=%0d want 17/1", out_seq, count); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++) wr_u(5'd2);
    out_ready = 1'b1;
    wr_u(5'd2);
    out_ready = 1'b0;
    vecs++; if (count !== 5'd16 || full !== 1'b1 || overflow_cnt !== 16'd0 || out_seq !== 16'd1)
      begin errs++; $display("FAIL pushpop got count=%0d full=%0b ovf=%0d seq=%0d want 16/1/0/1", count, full, overflow_cnt, out_seq); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 7; i++) wr_u(5'd6);
    vecs++; if (count !== 5'd7) begin errs++; $display("FAIL mid_count got %0d want 7", count); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (out_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin errs++; $display("FAIL mid_async got v=%0b count=%0d empty=%0b want 0/0/1", out_valid, count, empty); end
    @(negedge clk);
    rst = 1'b0;
    wr(5'd4, 32'h77, 32'h300);
    vecs++; if (out_seq !== 16'd0 || count !== 5'd1 || out_data !== 32'h77) begin errs++; $display("FAIL mid_first_seq got seq=%0d count=%0d d=%0h want 0/1/77", out_seq, count, out_data); end
  endtask

  task automatic test_wrap_saturate();
    logic [15:0] exp3 [3];
    exp3[0] = 16'hFFFE; exp3[1] = 16'hFFFF; exp3[2] = 16'h0000;
    do_reset();
    for (int i = 0; i < 16; i++) wr_u(5'd1);
    for (int i = 0; i < 65518; i++) wr_u(5'd1);
    vecs++; if (overflow_cnt !== 16'd65518) begin errs++; $display("FAIL wrap_ovf got %0d want 65518", overflow_cnt); end
    out_ready = 1'b1;
    repeat (16) @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr_u(5'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (out_valid !== 1'b1 || out_seq !== exp3[i]) begin errs++; $display("FAIL wrap_seq[%0d] got v=%0b seq=%0h want 1/%0h", i, out_valid, out_seq, exp3[i]); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) wr_u(5'd1);
    vecs++; if (out_seq !== 16'd1 || full !== 1'b1) begin errs++; $display("FAIL wrap_refill got seq=%0d full=%0b want 1/1", out_seq, full); end
    for (int i = 0; i < 17; i++) wr_u(5'd1);
    vecs++; if (overflow_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_reach got %0h want ffff", overflow_cnt); end
    for (int i = 0; i < 5; i++) wr_u(5'd1);
    vecs++; if (overflow_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_hold got %0h want ffff", overflow_cnt); end
  endtask

  task automatic test_filter();
`ifdef TRACE_FILTER_UNCHANGED_EN
    localparam int N = 2;
    logic [31:0] ed [N];
    ed[0] = 32'hAB; ed[1] = 32'hAC;
`else
    localparam int N = 3;
    logic [31:0] ed [N];
    ed[0] = 32'hAB; ed[1] = 32'hAB; ed[2] = 32'hAC;
`endif
    do_reset();
    wr(5'd3, 32'hAB, 32'h500);
    wr(5'd3, 32'hAB, 32'h504);
    wr(5'd3, 32'hAC, 32'h508);
    vecs++; if (count !== 5'(N)) begin errs++; $display("FAIL filter_count got %0d want %0d", count, N); end
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      vecs++; if (out_valid !== 1'b1 || out_seq !== 16'(i) || out_data !== ed[i]) begin errs++; $display("FAIL filter_entry[%0d] got v=%0b seq=%0d d=%0h want 1/%0d/%0h", i, out_valid, out_seq, out_data, i, ed[i]); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL filter_empty got %0b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_full_push_pop();
    test_reset_midstream();
    test_wrap_saturate();
    test_filter();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
